wb_uart_arbiter: RTL and testbench

WB_UART_ARBITER -- requirements
Module: wb_uart_arbiter

---
 rtl/wb_uart_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_wb_uart_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_uart_arbiter
// Purpose  : Two-master Wishbone arbiter in front of a single UART core, with
//            round-robin grant and locked multi-beat cycles.
//            Optional stalled-strobe bus-error timeout: WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_uart_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_m0_cyc,
  input  logic        i_m0_stb,
  input  logic        i_m0_we,
  input  logic [3:0]  i_m0_sel,
  input  logic [1:0]  i_m0_addr,
  input  logic [31:0] i_m0_data,
  output logic        o_m0_ack,
  output logic        o_m0_err,
  output logic [31:0] o_m0_data,
  input  logic        i_m1_cyc,
  input  logic        i_m1_stb,
  input  logic        i_m1_we,
  input  logic [3:0]  i_m1_sel,
  input  logic [1:0]  i_m1_addr,
  input  logic [31:0] i_m1_data,
  output logic        o_m1_ack,
  output logic        o_m1_err,
  output logic [31:0] o_m1_data,
  output logic        o_s_cyc,
  output logic        o_s_stb,
  output logic        o_s_we,
  output logic [3:0]  o_s_sel,
  output logic [1:0]  o_s_addr,
  output logic [31:0] o_s_data,
  input  logic        i_s_ack,
  input  logic [31:0] i_s_data,
  output logic [1:0]  o_grant
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_uart_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       last_owner;
  logic       last_owner_nx;
  logic [1:0] grant_nx;
  logic       own0;
  logic       own1;
  logic       timeout_hit;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  // Slave request mux: cyc qualifies stb, nothing reaches the slave unless owned
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_sel  = 4'd0;
    o_s_addr = 2'd0;
    o_s_data = 32'd0;
    if (own0) begin
      o_s_cyc  = i_m0_cyc;
      o_s_stb  = i_m0_cyc & i_m0_stb;
      o_s_we   = i_m0_we;
      o_s_sel  = i_m0_sel;
      o_s_addr = i_m0_addr;
      o_s_data = i_m0_data;
    end else if (own1) begin
      o_s_cyc  = i_m1_cyc;
      o_s_stb  = i_m1_cyc & i_m1_stb;
      o_s_we   = i_m1_we;
      o_s_sel  = i_m1_sel;
      o_s_addr = i_m1_addr;
      o_s_data = i_m1_data;
    end
  end

  assign o_m0_ack  = own0 & i_s_ack;
  assign o_m1_ack  = own1 & i_s_ack;
  assign o_m0_data = own0 ? i_s_data : 32'd0;
  assign o_m1_data = own1 ? i_s_data : 32'd0;

  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    case (state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          state_nx = last_owner ? OWN0 : OWN1;
        end else if (i_m0_cyc) begin
          state_nx = OWN0;
        end else if (i_m1_cyc) begin
          state_nx = OWN1;
        end
      end
      OWN0: begin
        if (!i_m0_cyc) begin
          state_nx = i_m1_cyc ? OWN1 : IDLE;
        end else if (timeout_hit) begin
          state_nx = DRAIN;
        end
      end
      OWN1: begin
        if (!i_m1_cyc) begin
          state_nx = i_m0_cyc ? OWN0 : IDLE;
        end else if (timeout_hit) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // last_owner still names the master whose cycle timed out
        if (last_owner) begin
          if (!i_m1_cyc) state_nx = i_m0_cyc ? OWN0 : IDLE;
        end else begin
          if (!i_m0_cyc) state_nx = i_m1_cyc ? OWN1 : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state_nx == OWN0) begin
      last_owner_nx = 1'b0;
    end else if (state_nx == OWN1) begin
      last_owner_nx = 1'b1;
    end
  end

  assign grant_nx = {(state_nx == OWN1), (state_nx == OWN0)};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      o_grant    <= 2'b00;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      o_grant    <= grant_nx;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       err_q;
  logic             stalled;

  assign stalled     = o_s_stb & ~i_s_ack;
  assign timeout_hit = stalled && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts consecutive stalled strobes; any break or owner change restarts it
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tmo_cnt <= '0;
      err_q   <= 2'b00;
    end else begin
      if (!stalled || (state_nx != state)) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      err_q <= timeout_hit ? {own1, own0} : 2'b00;
    end
  end

  assign o_m0_err = err_q[0];
  assign o_m1_err = err_q[1];
`else
  assign timeout_hit = 1'b0;
  assign o_m0_err    = 1'b0;
  assign o_m1_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_uart_arbiter
// Purpose  : Directed self-checking bench for wb_uart_arbiter (either build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_uart_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [1:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic        s_ack;
  logic [31:0] s_rdata;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_uart_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_sel(m0_sel),
    .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_data(m0_rdata),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_sel(m1_sel),
    .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_data(m1_rdata),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_sel(s_sel),
    .o_s_addr(s_addr), .o_s_data(s_wdata),
    .i_s_ack(s_ack), .i_s_data(s_rdata),
    .o_grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_addr = 2'd0; m0_wdata = 32'd0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_addr = 2'd0; m1_wdata = 32'd0;
    s_ack = 0; s_rdata = 32'd0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_inputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    // Requests during reset must not reach the slave
    m0_cyc = 1; m0_stb = 1;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_s_cyc", 32'(s_cyc), 32'h0);
    check("rst_s_stb", 32'(s_stb), 32'h0);
    check("rst_m0_err", 32'(m0_err), 32'h0);
    apply_reset();

    // Single m0 read of addr 2, ack after three cycles
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 2'b10; m0_sel = 4'hF;
    #1;
    check("rd_grant_pre", 32'(grant), 32'h0);
    check("rd_s_cyc_pre", 32'(s_cyc), 32'h0);
    step();
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_s_cyc", 32'(s_cyc), 32'h1);
    check("rd_s_addr", 32'(s_addr), 32'h2);
    step();
    step();
    check("rd_ack_wait", 32'(m0_ack), 32'h0);
    s_ack = 1; s_rdata = 32'h0000_0041;
    #1;
    check("rd_m0_ack", 32'(m0_ack), 32'h1);
    check("rd_m0_data", m0_rdata, 32'h41);
    check("rd_m1_ack", 32'(m1_ack), 32'h0);
    check("rd_m1_data", m1_rdata, 32'h0);
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    check("rd_ack_single", 32'(m0_ack), 32'h0);
    check("rd_s_cyc_drop", 32'(s_cyc), 32'h0);
    step();
    check("rd_grant_idle", 32'(grant), 32'h0);

    // Simultaneous requests alternate, m0 first after reset
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      step();
      check($sformatf("rr%0d_grant_m0", r), 32'(grant), 32'h1);
      s_ack = 1;
      #1;
      check($sformatf("rr%0d_m0_ack", r), 32'({m1_ack, m0_ack}), 32'h1);
      step();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      step();
      check($sformatf("rr%0d_grant_m1", r), 32'(grant), 32'h2);
      s_ack = 1;
      #1;
      check($sformatf("rr%0d_m1_ack", r), 32'({m1_ack, m0_ack}), 32'h2);
      step();
      s_ack = 0; m1_cyc = 0; m1_stb = 0;
      step();
      check($sformatf("rr%0d_idle", r), 32'(grant), 32'h0);
    end

    // m1 write locked against a competing m0 request, then back-to-back handoff
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 2'b00; m1_sel = 4'hF; m1_wdata = 32'd434;
    step();
    check("lk_grant_m1", 32'(grant), 32'h2);
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 2'b11; m0_sel = 4'h1; m0_wdata = 32'hDEAD_BEEF;
    #1;
    check("lk_s_data", s_wdata, 32'd434);
    check("lk_s_we", 32'(s_we), 32'h1);
    check("lk_s_addr", 32'(s_addr), 32'h0);
    check("lk_s_sel", 32'(s_sel), 32'hF);
    step();
    check("lk_grant_hold", 32'(grant), 32'h2);
    s_ack = 1;
    #1;
    check("lk_acks", 32'({m1_ack, m0_ack}), 32'h2);
    step();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step();
    check("lk_grant_m0", 32'(grant), 32'h1);
    check("lk_s_addr_m0", 32'(s_addr), 32'h3);
    check("lk_s_data_m0", s_wdata, 32'hDEAD_BEEF);
    m0_cyc = 0; m0_stb = 0;
    step();

    // Stalled strobe: bus error after 16 cycles, or indefinite wait
    apply_reset();
    m0_cyc = 1; m0_stb = 1;
    step();
    check("to_grant", 32'(grant), 32'h1);
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("to_wait%0d", i), 32'({m0_err, grant}), 32'h1);
    end
    step();
    check("to_m0_err", 32'(m0_err), 32'h1);
    check("to_m1_err", 32'(m1_err), 32'h0);
    check("to_grant_drain", 32'(grant), 32'h0);
    check("to_s_cyc_drain", 32'(s_cyc), 32'h0);
    s_ack = 1;
    #1;
    check("to_late_ack", 32'({m1_ack, m0_ack}), 32'h0);
    step();
    check("to_err_pulse", 32'(m0_err), 32'h0);
    check("to_still_drain", 32'({s_stb, grant}), 32'h0);
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step();
    check("to_idle", 32'(grant), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("st_wait%0d", i), 32'({m0_err, grant}), 32'h1);
    end
    s_ack = 1;
    #1;
    check("st_ack", 32'(m0_ack), 32'h1);
    step();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step();
    check("st_idle", 32'(grant), 32'h0);
`endif

    // Asynchronous reset mid-read, then normal m1 grant
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 2'b01;
    step();
    check("ar_grant", 32'(grant), 32'h1);
    #1;
    s_ack = 1; s_rdata = 32'h1234_5678;
    reset_n = 0;
    #1;
    check("ar_grant0", 32'(grant), 32'h0);
    check("ar_s_cyc", 32'({s_cyc, s_stb}), 32'h0);
    check("ar_s_addr", 32'(s_addr), 32'h0);
    check("ar_acks", 32'({m1_ack, m0_ack}), 32'h0);
    check("ar_errs", 32'({m1_err, m0_err}), 32'h0);
    check("ar_m0_data", m0_rdata, 32'h0);
    #1;
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    reset_n = 1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 2'b01; m1_wdata = 32'h55;
    step();
    check("ar_grant_m1", 32'(grant), 32'h2);
    check("ar_s_data_m1", s_wdata, 32'h55);
    m1_cyc = 0; m1_stb = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
